lh_ptxt_framer: RTL and testbench
=================================

// Module: lh_ptxt_framer
// PURPOSE
// - Transmit side of the light-hash plaintext stream: buffers one message from an upstream
//   byte source, then drives the hash core's ptxt_char/ptxt_valid with the framing
//   start byte 0xFF, the body bytes and the finish byte 0x00.
// - Captures the core's 64-bit digest on digest_ready and presents it upstream.
// - Screens characters so that only [0-9A-Za-z] ever reach the core.
// PARAMETERS
// - DEPTH      16    message buffer depth in bytes; it is also the maximum message length.
// - CHAR_GAP   1     idle cycles (ptxt_valid=0) after each framed byte; 0 means back-to-back.
// - TIMEOUT    1024  maximum cycles spent in WAIT_DIGEST before err_timeout.
// PORTS
// - clk               in   1   single clock, rising edge
// - rst_n             in   1   asynchronous, active-low reset
// - msg_char          in   8   upstream message byte
// - msg_valid         in   1   msg_char is valid
// - msg_last          in   1   the byte is the final byte of the message
// - msg_ready         out  1   framer accepts a byte this cycle
// - ptxt_char         out  8   byte driven to the hash core
// - ptxt_valid        out  1   ptxt_char is valid for exactly one cycle
// - digest_char       in   64  digest from the hash core
// - digest_ready      in   1   digest_char is valid (level)
// - digest_out        out  64  captured digest, held until the next capture
// - digest_out_valid  out  1   one-cycle pulse when digest_out is updated
// - busy              out  1   high in every state except LOAD
// - err_invalid_char  out  1   one-cycle pulse: message dropped, it held a non-alphanumeric byte
// - err_overflow      out  1   one-cycle pulse: message dropped, it was longer than DEPTH bytes
// - err_timeout       out  1   one-cycle pulse: no digest_ready within TIMEOUT cycles
// BEHAVIOUR
// - Reset values: all outputs 0, except msg_ready=1 and ptxt_char=0x00. FIFO is emptied,
//   drop flags are cleared, FSM goes to LOAD. Reset asserted mid-frame forces
//   ptxt_valid=0 at once (asynchronously).
// - Upstream handshake: a byte is accepted when msg_valid && msg_ready.
//   msg_ready=1 only in LOAD.
// - LOAD state:
//   - Each accepted byte is written to the FIFO when it is alphanumeric, the FIFO is not
//     full and no drop flag is set.
//   - A non-alphanumeric byte sets drop_inv. A byte arriving with count==DEPTH sets drop_ovf.
//   - On an accepted msg_last byte (the last byte is checked and stored like the others):
//     - If any drop flag is set: flush the FIFO, clear the flags, stay in LOAD, and pulse
//       err_invalid_char and/or err_overflow on the next cycle. Both can pulse together.
//     - Otherwise go to START.
// - START: ptxt_char=0xFF and ptxt_valid=1 for one cycle, followed by CHAR_GAP idle cycles,
//   then BODY.
// - BODY: pop one byte per slot and drive it with ptxt_valid=1 for one cycle, each followed
//   by CHAR_GAP idle cycles. After the FIFO empties, go to FINISH.
// - FINISH: ptxt_char=0x00 and ptxt_valid=1 for one cycle, then WAIT_DIGEST.
// - WAIT_DIGEST:
//   - The first cycle with digest_ready=1 registers digest_char into digest_out, pulses
//     digest_out_valid on the next cycle, and returns to LOAD.
//   - If the cycle counter reaches TIMEOUT first, pulse err_timeout, leave digest_out
//     unchanged, and return to LOAD.
// - Frame length: ptxt_valid is high for exactly N+2 cycles per N-byte message.
// - Frame period: 0xFF to 0x00 spans (N+1)*(CHAR_GAP+1)+1 cycles.
// - Outside a frame, ptxt_valid=0. A 0xFF or 0x00 byte never appears in the body,
//   because screening rejects it.
// - A digest_ready seen in any state other than WAIT_DIGEST is ignored.
// - Counter widths: FIFO count is $clog2(DEPTH+1) bits; the timeout counter is
//   $clog2(TIMEOUT+1) bits; the gap counter is $clog2(CHAR_GAP+1) bits. No counter wraps.
// STRUCTURE
// - lh_pkg holds:
//   - LH_START_CHAR=8'hFF and LH_FINISH_CHAR=8'h00
//   - the ASCII bound localparams ('0','9','A','Z','a','z')
//   - function lh_is_alnum(byte)
//   - typedef enum lh_framer_state_e {LOAD,START,BODY,FINISH,WAIT_DIGEST}
// - Sub-module lh_byte_fifo: synchronous FIFO with parameter DEPTH, push/pop/flush inputs
//   and full/empty/count outputs.
// TESTING
// - Message "AB" (msg_last on 'B'), CHAR_GAP=1:
//   - ptxt_valid bytes are FF,41,42,00 at cycles t, t+2, t+4, t+6.
//   - Model asserts digest_ready with 64'h0123_4567_89AB_CDEF.
//   - digest_out_valid pulses once, and digest_out equals that value.
// - "a!9": err_invalid_char pulses once, ptxt_valid never rises, and msg_ready stays 1.
//   The following message "z" frames as FF,7A,00.
// - DEPTH=16 with a 17-byte message: err_overflow pulses once, and no frame is sent.
// - "Q" with digest_ready held low: err_timeout pulses exactly TIMEOUT cycles after the
//   0x00 byte, and digest_out keeps its previous value.
// - rst_n asserted while the second of 4 body bytes is on the bus:
//   - ptxt_valid drops to 0 immediately; all outputs take their reset values.
//   - A new message "X" then frames correctly.
// - CHAR_GAP=0 with a 16-byte message: 18 consecutive ptxt_valid cycles, and
//   digest_ready held for 3 cycles produces a single digest_out_valid pulse.

Source files
------------

// File: rtl/lh_pkg.sv
// rtl/lh_pkg.sv - shared constants, state type and character screen for the light-hash framer
package lh_pkg;

    localparam logic [7:0] LH_START_CHAR  = 8'hFF;
    localparam logic [7:0] LH_FINISH_CHAR = 8'h00;

    localparam logic [7:0] LH_CHAR_0    = 8'h30;
    localparam logic [7:0] LH_CHAR_9    = 8'h39;
    localparam logic [7:0] LH_CHAR_UC_A = 8'h41;
    localparam logic [7:0] LH_CHAR_UC_Z = 8'h5A;
    localparam logic [7:0] LH_CHAR_LC_A = 8'h61;
    localparam logic [7:0] LH_CHAR_LC_Z = 8'h7A;

    typedef enum logic [2:0] {
        LOAD,
        START,
        BODY,
        FINISH,
        WAIT_DIGEST
    } lh_framer_state_e;

    // Framing bytes 0xFF/0x00 fall outside every range, so they can never leak into a body.
    function automatic logic lh_is_alnum(input logic [7:0] c);
        return ((c >= LH_CHAR_0)    && (c <= LH_CHAR_9))    ||
               ((c >= LH_CHAR_UC_A) && (c <= LH_CHAR_UC_Z)) ||
               ((c >= LH_CHAR_LC_A) && (c <= LH_CHAR_LC_Z));
    endfunction

endpackage

// File: rtl/lh_byte_fifo.sv
// rtl/lh_byte_fifo.sv - show-ahead byte FIFO holding one message body
module lh_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [7:0]                 wr_data,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lh_ptxt_framer.sv
// rtl/lh_ptxt_framer.sv - buffers a screened message, frames it to the hash core, captures the digest
module lh_ptxt_framer
    import lh_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CHAR_GAP = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  msg_char,
    input  logic        msg_valid,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic [7:0]  ptxt_char,
    output logic        ptxt_valid,
    input  logic [63:0] digest_char,
    input  logic        digest_ready,
    output logic [63:0] digest_out,
    output logic        digest_out_valid,
    output logic        busy,
    output logic        err_invalid_char,
    output logic        err_overflow,
    output logic        err_timeout
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (CHAR_GAP > 0) ? $clog2(CHAR_GAP + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    lh_framer_state_e state;
    logic             drop_inv;
    logic             drop_ovf;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             accept;
    logic             char_ok;
    logic             set_inv;
    logic             set_ovf;
    logic             push;
    logic             flush;
    logic             slot_end;
    logic             pop;

    // msg_ready is only ever high in LOAD, so accept implies LOAD.
    always_comb begin
        accept   = msg_valid && msg_ready;
        char_ok  = lh_is_alnum(msg_char);
        set_inv  = drop_inv || !char_ok;
        set_ovf  = drop_ovf || fifo_full;
        push     = accept && char_ok && (fifo_count < CW'(DEPTH)) && !drop_inv && !drop_ovf;
        flush    = accept && msg_last && (set_inv || set_ovf);
        slot_end = ((state == START) || (state == BODY)) && (gap_cnt == '0);
        pop      = slot_end && !fifo_empty;
    end

    lh_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (msg_char),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Each framed byte is loaded together with gap_cnt=CHAR_GAP; the slot ends when it drains to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= LOAD;
            msg_ready        <= 1'b1;
            ptxt_char        <= LH_FINISH_CHAR;
            ptxt_valid       <= 1'b0;
            digest_out       <= '0;
            digest_out_valid <= 1'b0;
            busy             <= 1'b0;
            err_invalid_char <= 1'b0;
            err_overflow     <= 1'b0;
            err_timeout      <= 1'b0;
            drop_inv         <= 1'b0;
            drop_ovf         <= 1'b0;
            gap_cnt          <= '0;
            tmo_cnt          <= '0;
        end else begin
            ptxt_valid       <= 1'b0;
            digest_out_valid <= 1'b0;
            err_invalid_char <= 1'b0;
            err_overflow     <= 1'b0;
            err_timeout      <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (msg_last) begin
                            drop_inv <= 1'b0;
                            drop_ovf <= 1'b0;
                            if (set_inv || set_ovf) begin
                                err_invalid_char <= set_inv;
                                err_overflow     <= set_ovf;
                            end else begin
                                state      <= START;
                                msg_ready  <= 1'b0;
                                busy       <= 1'b1;
                                ptxt_char  <= LH_START_CHAR;
                                ptxt_valid <= 1'b1;
                                gap_cnt    <= GW'(CHAR_GAP);
                            end
                        end else begin
                            drop_inv <= set_inv;
                            drop_ovf <= set_ovf;
                        end
                    end
                end
                START, BODY: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (!fifo_empty) begin
                        state      <= BODY;
                        ptxt_char  <= fifo_data;
                        ptxt_valid <= 1'b1;
                        gap_cnt    <= GW'(CHAR_GAP);
                    end else begin
                        state      <= FINISH;
                        ptxt_char  <= LH_FINISH_CHAR;
                        ptxt_valid <= 1'b1;
                    end
                end
                FINISH: begin
                    state   <= WAIT_DIGEST;
                    tmo_cnt <= TW'(1);
                end
                WAIT_DIGEST: begin
                    // tmo_cnt counts cycles since the finish byte, so the pulse lands TIMEOUT cycles after it.
                    if (digest_ready) begin
                        digest_out       <= digest_char;
                        digest_out_valid <= 1'b1;
                        state            <= LOAD;
                        msg_ready        <= 1'b1;
                        busy             <= 1'b0;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= LOAD;
                        msg_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= LOAD;
                    msg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lh_ptxt_framer.sv
// tb/tb_lh_ptxt_framer.sv - directed self-checking bench for lh_ptxt_framer
module tb_lh_ptxt_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n0;
    logic [7:0]  msg_char;
    logic        msg_valid;
    logic        msg_last;
    logic [63:0] digest_char;
    logic        digest_ready;

    logic        msg_ready, ptxt_valid, digest_out_valid, busy;
    logic        err_invalid_char, err_overflow, err_timeout;
    logic [7:0]  ptxt_char;
    logic [63:0] digest_out;

    logic        msg_ready0, ptxt_valid0, digest_out_valid0, busy0;
    logic        err_invalid_char0, err_overflow0, err_timeout0;
    logic [7:0]  ptxt_char0;
    logic [63:0] digest_out0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         pv_cyc[$];
    logic [7:0] pv_byte[$];
    int         pv0_cyc[$];
    logic [7:0] pv0_byte[$];
    int n_dov = 0, n_einv = 0, n_eovf = 0, n_etmo = 0, n_nrdy = 0, tmo_cyc = 0;
    int n_dov0 = 0, n_err0 = 0;

    always #5 clk = ~clk;

    lh_ptxt_framer #(.DEPTH(16), .CHAR_GAP(1), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .msg_char(msg_char), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
        .digest_char(digest_char), .digest_ready(digest_ready),
        .digest_out(digest_out), .digest_out_valid(digest_out_valid), .busy(busy),
        .err_invalid_char(err_invalid_char), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    lh_ptxt_framer #(.DEPTH(16), .CHAR_GAP(0), .TIMEOUT(1024)) u_dut0 (
        .clk(clk), .rst_n(rst_n0),
        .msg_char(msg_char), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready0),
        .ptxt_char(ptxt_char0), .ptxt_valid(ptxt_valid0),
        .digest_char(digest_char), .digest_ready(digest_ready),
        .digest_out(digest_out0), .digest_out_valid(digest_out_valid0), .busy(busy0),
        .err_invalid_char(err_invalid_char0), .err_overflow(err_overflow0), .err_timeout(err_timeout0)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ptxt_valid === 1'b1) begin
            pv_cyc.push_back(cyc);
            pv_byte.push_back(ptxt_char);
        end
        if (ptxt_valid0 === 1'b1) begin
            pv0_cyc.push_back(cyc);
            pv0_byte.push_back(ptxt_char0);
        end
        if (digest_out_valid === 1'b1)  n_dov  <= n_dov + 1;
        if (digest_out_valid0 === 1'b1) n_dov0 <= n_dov0 + 1;
        if (err_invalid_char === 1'b1)  n_einv <= n_einv + 1;
        if (err_overflow === 1'b1)      n_eovf <= n_eovf + 1;
        if (err_timeout === 1'b1) begin
            n_etmo  <= n_etmo + 1;
            tmo_cyc <= cyc;
        end
        if (msg_ready !== 1'b1) n_nrdy <= n_nrdy + 1;
        if ((err_invalid_char0 | err_overflow0 | err_timeout0 | busy0) === 1'b1 && rst_n0 === 1'b0)
            n_err0 <= n_err0 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input string s, input bit use0);
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            msg_char  = s[i];
            msg_valid = 1'b1;
            msg_last  = (i == s.len() - 1);
            guard     = 0;
            forever begin
                @(negedge clk);
                if ((use0 ? msg_ready0 : msg_ready) === 1'b1) break;
                guard++;
                if (guard > 100) break;
            end
            if (guard > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_accept: byte %0d of '%s' not accepted, required acceptance within 100 cycles", i, s);
            end
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_frame(input int target, input bit use0, output bit ok);
        int g = 0;
        while (((use0 ? pv0_byte.size() : pv_byte.size()) < target) && (g < 300)) begin
            @(negedge clk);
            #1;
            g++;
        end
        ok = ((use0 ? pv0_byte.size() : pv_byte.size()) >= target);
    endtask

    task automatic drive_digest(input logic [63:0] value, input int cycles);
        @(posedge clk);
        #1;
        digest_char  = value;
        digest_ready = 1'b1;
        tick(cycles);
        digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (msg_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_msg_ready: got %b, required 1", msg_ready); end
        n_cmp++; if (ptxt_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_ptxt_valid: got %b, required 0", ptxt_valid); end
        n_cmp++; if (ptxt_char !== 8'h00)   begin n_fail++; $display("FAIL reset_ptxt_char: got %h, required 00", ptxt_char); end
        n_cmp++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (digest_out !== 64'h0)  begin n_fail++; $display("FAIL reset_digest_out: got %h, required 0", digest_out); end
        n_cmp++;
        if ({digest_out_valid, err_invalid_char, err_overflow, err_timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b, required 0000",
                     {digest_out_valid, err_invalid_char, err_overflow, err_timeout});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ab();
        logic [7:0] exp_b [4] = '{8'hFF, 8'h41, 8'h42, 8'h00};
        int  b = pv_byte.size();
        int  d = n_dov;
        bit  ok;
        send_msg("AB", 1'b0);
        wait_frame(b + 4, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ab_frame_done: got %0d bytes, required 4", pv_byte.size() - b); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (pv_byte[b+k] !== exp_b[k]) begin n_fail++; $display("FAIL ab_byte%0d: got %h, required %h", k, pv_byte[b+k], exp_b[k]); end
            n_cmp++;
            if (pv_cyc[b+k] - pv_cyc[b] !== 2 * k) begin
                n_fail++;
                $display("FAIL ab_slot%0d: got offset %0d, required %0d", k, pv_cyc[b+k] - pv_cyc[b], 2 * k);
            end
        end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ab_busy_in_frame: got %b, required 1", busy); end
        drive_digest(64'h0123_4567_89AB_CDEF, 1);
        tick(3);
        n_cmp++; if (n_dov - d !== 1) begin n_fail++; $display("FAIL ab_dov_pulses: got %0d, required 1", n_dov - d); end
        n_cmp++; if (digest_out !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL ab_digest: got %h, required 0123456789abcdef", digest_out); end
        n_cmp++; if (msg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ab_back_to_load: got ready=%b busy=%b, required 1/0", msg_ready, busy); end
    endtask

    task automatic test_invalid();
        logic [7:0] exp_b [3] = '{8'hFF, 8'h7A, 8'h00};
        int b  = pv_byte.size();
        int ei = n_einv;
        int eo = n_eovf;
        int nr = n_nrdy;
        bit ok;
        send_msg("a!9", 1'b0);
        tick(8);
        n_cmp++; if (n_einv - ei !== 1)       begin n_fail++; $display("FAIL inv_err_pulses: got %0d, required 1", n_einv - ei); end
        n_cmp++; if (n_eovf - eo !== 0)       begin n_fail++; $display("FAIL inv_ovf_pulses: got %0d, required 0", n_eovf - eo); end
        n_cmp++; if (pv_byte.size() !== b)    begin n_fail++; $display("FAIL inv_no_frame: got %0d bytes, required 0", pv_byte.size() - b); end
        n_cmp++; if (n_nrdy - nr !== 0)       begin n_fail++; $display("FAIL inv_ready_low: got %0d low cycles, required 0", n_nrdy - nr); end
        b = pv_byte.size();
        send_msg("z", 1'b0);
        wait_frame(b + 3, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL z_frame_done: got %0d bytes, required 3", pv_byte.size() - b); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pv_byte[b+k] !== exp_b[k]) begin n_fail++; $display("FAIL z_byte%0d: got %h, required %h", k, pv_byte[b+k], exp_b[k]); end
        end
        drive_digest(64'hFEDC_BA98_7654_3210, 1);
        tick(3);
        n_cmp++; if (digest_out !== 64'hFEDC_BA98_7654_3210) begin n_fail++; $display("FAIL z_digest: got %h, required fedcba9876543210", digest_out); end
    endtask

    task automatic test_overflow();
        int b  = pv_byte.size();
        int ei = n_einv;
        int eo = n_eovf;
        send_msg("ABCDEFGHIJKLMNOPQ", 1'b0);
        tick(10);
        n_cmp++; if (n_eovf - eo !== 1)    begin n_fail++; $display("FAIL ovf_pulses: got %0d, required 1", n_eovf - eo); end
        n_cmp++; if (n_einv - ei !== 0)    begin n_fail++; $display("FAIL ovf_inv_pulses: got %0d, required 0", n_einv - ei); end
        n_cmp++; if (pv_byte.size() !== b) begin n_fail++; $display("FAIL ovf_no_frame: got %0d bytes, required 0", pv_byte.size() - b); end
        n_cmp++; if (msg_ready !== 1'b1)   begin n_fail++; $display("FAIL ovf_ready: got %b, required 1", msg_ready); end
    endtask

    task automatic test_timeout();
        int b  = pv_byte.size();
        int dv = n_dov;
        int et = n_etmo;
        int f;
        int g  = 0;
        bit ok;
        send_msg("Q", 1'b0);
        wait_frame(b + 3, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL q_frame_done: got %0d bytes, required 3", pv_byte.size() - b); end
        n_cmp++; if (pv_byte[b+1] !== 8'h51) begin n_fail++; $display("FAIL q_body: got %h, required 51", pv_byte[b+1]); end
        f = pv_cyc[b+2];
        while ((n_etmo == et) && (g < 1100)) begin
            @(negedge clk);
            #1;
            g++;
        end
        n_cmp++; if (n_etmo == et) begin n_fail++; $display("FAIL tmo_seen: got no pulse, required pulse within 1100 cycles"); end
        n_cmp++; if (tmo_cyc - f !== 1024) begin n_fail++; $display("FAIL tmo_latency: got %0d, required 1024", tmo_cyc - f); end
        tick(5);
        n_cmp++; if (n_etmo - et !== 1) begin n_fail++; $display("FAIL tmo_pulses: got %0d, required 1", n_etmo - et); end
        n_cmp++; if (n_dov - dv !== 0)  begin n_fail++; $display("FAIL tmo_dov: got %0d, required 0", n_dov - dv); end
        n_cmp++; if (digest_out !== 64'hFEDC_BA98_7654_3210) begin n_fail++; $display("FAIL tmo_digest_kept: got %h, required fedcba9876543210", digest_out); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b [3] = '{8'hFF, 8'h58, 8'h00};
        int b = pv_byte.size();
        bit ok;
        send_msg("ABCD", 1'b0);
        wait_frame(b + 3, 1'b0, ok);
        n_cmp++;
        if (!ok || ptxt_valid !== 1'b1 || ptxt_char !== 8'h42) begin
            n_fail++;
            $display("FAIL mid_before: got valid=%b char=%h, required 1/42", ptxt_valid, ptxt_char);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ptxt_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_valid_drop: got %b, required 0", ptxt_valid); end
        n_cmp++; if (ptxt_char !== 8'h00)  begin n_fail++; $display("FAIL mid_char: got %h, required 00", ptxt_char); end
        n_cmp++; if (msg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_ready_busy: got %b/%b, required 1/0", msg_ready, busy); end
        n_cmp++; if (digest_out !== 64'h0) begin n_fail++; $display("FAIL mid_digest: got %h, required 0", digest_out); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        b = pv_byte.size();
        send_msg("X", 1'b0);
        wait_frame(b + 3, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL x_frame_done: got %0d bytes, required 3", pv_byte.size() - b); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pv_byte[b+k] !== exp_b[k]) begin n_fail++; $display("FAIL x_byte%0d: got %h, required %h", k, pv_byte[b+k], exp_b[k]); end
        end
        drive_digest(64'h1111_2222_3333_4444, 1);
        tick(3);
    endtask

    task automatic test_back_to_back();
        string s = "0123456789abcdef";
        int    b;
        int    d;
        bit    ok;
        rst_n = 1'b0;
        tick(1);
        n_cmp++; if (n_err0 !== 0) begin n_fail++; $display("FAIL b2b_idle_outputs: got %0d active cycles, required 0", n_err0); end
        rst_n0 = 1'b1;
        tick(2);
        b = pv0_byte.size();
        d = n_dov0;
        send_msg(s, 1'b1);
        wait_frame(b + 18, 1'b1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_frame_done: got %0d bytes, required 18", pv0_byte.size() - b); end
        n_cmp++; if (pv0_cyc[b+17] - pv0_cyc[b] !== 17) begin n_fail++; $display("FAIL b2b_span: got %0d, required 17", pv0_cyc[b+17] - pv0_cyc[b]); end
        n_cmp++; if (pv0_byte[b] !== 8'hFF)    begin n_fail++; $display("FAIL b2b_start: got %h, required ff", pv0_byte[b]); end
        n_cmp++; if (pv0_byte[b+17] !== 8'h00) begin n_fail++; $display("FAIL b2b_finish: got %h, required 00", pv0_byte[b+17]); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (pv0_byte[b+1+k] !== s[k]) begin n_fail++; $display("FAIL b2b_body%0d: got %h, required %h", k, pv0_byte[b+1+k], s[k]); end
        end
        drive_digest(64'hA5A5_5A5A_0F0F_F0F0, 3);
        tick(3);
        n_cmp++; if (n_dov0 - d !== 1) begin n_fail++; $display("FAIL b2b_dov_pulses: got %0d, required 1", n_dov0 - d); end
        n_cmp++; if (digest_out0 !== 64'hA5A5_5A5A_0F0F_F0F0) begin n_fail++; $display("FAIL b2b_digest: got %h, required a5a55a5a0f0ff0f0", digest_out0); end
        n_cmp++; if (pv0_byte.size() !== b + 18) begin n_fail++; $display("FAIL b2b_extra_bytes: got %0d, required 18", pv0_byte.size() - b); end
    endtask

    initial begin
        rst_n        = 1'b0;
        rst_n0       = 1'b0;
        msg_char     = 8'h00;
        msg_valid    = 1'b0;
        msg_last     = 1'b0;
        digest_char  = 64'h0;
        digest_ready = 1'b0;
        test_reset();
        test_ab();
        test_invalid();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
